// File: rtl/colorbars_gen.sv
// Video timing and test-pattern generator: VGA-style hsync/vsync/de plus RGB
// for a configurable raster, with four patterns selected per frame.
// Optional feature: define COLORBARS_SCROLL_EN to enable per-frame horizontal scroll.
module colorbars_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned SYNC_NEG   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [3*COLOR_BITS-1:0]   solid_rgb,
  input  logic                      scroll,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic                      frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  // At least 6 bits so the checkerboard can always use bit 5.
  localparam int unsigned VW      = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
  localparam int unsigned XW      = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HAct     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VAct     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] XLast    = XW'(H_ACTIVE - 1);
  localparam logic [BW-1:0] PosLast  = BW'(BAR_W - 1);
  localparam logic          SyncOn   = (SYNC_NEG != 0) ? 1'b0 : 1'b1;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          line_end, frame_end;

  logic [1:0]              mode_q;
  logic [3*COLOR_BITS-1:0] color_q;

  // Pattern position tracks hcnt: x coordinate, bar index and offset within the bar.
  logic [XW-1:0] x_q, x_d, x_load;
  logic [2:0]    bar_q, bar_d, bar_load;
  logic [BW-1:0] pos_q, pos_d, pos_load;

  logic [COLOR_BITS-1:0] grey, pr, pg, pb;
  logic                  active;

  assign line_end  = (hcnt_q == HLast);
  assign frame_end = line_end && (vcnt_q == VLast);
  assign active    = (hcnt_q < HAct) && (vcnt_q < VAct);

  // Raster counter next state: hcnt wraps every line, vcnt steps on each hcnt wrap.
  always_comb begin
    hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (line_end) begin
      vcnt_d = frame_end ? '0 : vcnt_q + 1'b1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Pattern settings are latched only on the last cycle of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      color_q <= '0;
    end else if (frame_end) begin
      mode_q  <= mode;
      color_q <= solid_rgb;
    end
  end

`ifdef COLORBARS_SCROLL_EN
  logic [XW-1:0] off_q, off_d;
  logic [2:0]    off_bar_q, off_bar_d;
  logic [BW-1:0] off_pos_q, off_pos_d;

  // Offset advances by one pixel per frame, with its bar position kept alongside.
  always_comb begin
    off_d     = off_q;
    off_bar_d = off_bar_q;
    off_pos_d = off_pos_q;
    if (frame_end && scroll) begin
      off_d = (off_q == XLast) ? '0 : off_q + 1'b1;
      if (off_pos_q == PosLast) begin
        off_pos_d = '0;
        off_bar_d = off_bar_q + 1'b1;
      end else begin
        off_pos_d = off_pos_q + 1'b1;
      end
    end
  end

  // Scroll offset registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q     <= '0;
      off_bar_q <= '0;
      off_pos_q <= '0;
    end else begin
      off_q     <= off_d;
      off_bar_q <= off_bar_d;
      off_pos_q <= off_pos_d;
    end
  end

  // Next-state offset so a frame-end update is already visible on the first line.
  assign x_load   = off_d;
  assign bar_load = off_bar_d;
  assign pos_load = off_pos_d;
`else
  logic unused_scroll;
  assign unused_scroll = scroll;
  assign x_load   = '0;
  assign bar_load = '0;
  assign pos_load = '0;
`endif

  // Pattern position: reload at line start, step through visible pixels, hold in blanking.
  always_comb begin
    x_d   = x_q;
    bar_d = bar_q;
    pos_d = pos_q;
    if (line_end) begin
      x_d   = x_load;
      bar_d = bar_load;
      pos_d = pos_load;
    end else if (hcnt_q < HAct) begin
      x_d = (x_q == XLast) ? '0 : x_q + 1'b1;
      if (pos_q == PosLast) begin
        pos_d = '0;
        bar_d = bar_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // Pattern position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      bar_q <= '0;
      pos_q <= '0;
    end else begin
      x_q   <= x_d;
      bar_q <= bar_d;
      pos_q <= pos_d;
    end
  end

  // Ramp steps are whole groups of bars when the step count is at most 8.
  if (COLOR_BITS <= 3) begin : g_grey_bar
    assign grey = COLOR_BITS'(bar_q >> (3 - COLOR_BITS));
  end else begin : g_grey_div
    logic [XW-1:0] quo;
    assign quo  = x_q / XW'(H_ACTIVE >> COLOR_BITS);
    assign grey = (quo > XW'((1 << COLOR_BITS) - 1)) ? '1 : COLOR_BITS'(quo);
  end

  // Pixel colour for the current pattern position.
  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      2'd0: begin
        // Bar order white..black: R off for bars 2,3,6,7, G off for 4..7, B off for odd.
        pr = {COLOR_BITS{~bar_q[1]}};
        pg = {COLOR_BITS{~bar_q[2]}};
        pb = {COLOR_BITS{~bar_q[0]}};
      end
      2'd1: begin
        pr = grey;
        pg = grey;
        pb = grey;
      end
      2'd2: begin
        if (!(x_q[5] ^ vcnt_q[5])) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end
      end
      default: {pr, pg, pb} = color_q;
    endcase
  end

  // Registered outputs, all one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SyncOn;
      vsync       <= ~SyncOn;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ((hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd)) ? SyncOn : ~SyncOn;
      vsync       <= ((vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd)) ? SyncOn : ~SyncOn;
      de          <= active;
      r           <= active ? pr : '0;
      g           <= active ? pg : '0;
      b           <= active ? pb : '0;
      frame_start <= (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

endmodule

// File: tb/tb_colorbars_gen.sv
// Bench for colorbars_gen on a reduced raster: a frame-level reference model
// pushes the expected output for every clock; a monitor pops and compares.
module tb_colorbars_gen;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int CB = 2;
  localparam int MAXC = (1 << CB) - 1;
  localparam int OW = 4 + 3 * CB;

  logic clk = 1'b0;
  logic rst, scroll, hsync, vsync, de, frame_start;
  logic [1:0] mode;
  logic [3*CB-1:0] solid_rgb;
  logic [CB-1:0] r, g, b;

  always #5 clk = ~clk;

  colorbars_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLOR_BITS(CB), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb), .scroll(scroll),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [OW-1:0] val;
    int            h;
    int            v;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit done = 0;

  // Reference model state (position the DUT counters hold during the cycle).
  int m_h, m_v, m_mode, m_off;
  logic [3*CB-1:0] m_col;

  function automatic logic [OW-1:0] ref_pixel(int h, int v, int md, logic [3*CB-1:0] col,
                                              int off);
    int x, bar, code;
    logic act, hs, vs, fs;
    logic [CB-1:0] rr, gg, bb;
    act = (h < HA) && (v < VA);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
    fs  = (h == 0) && (v == 0);
    x   = (h + off) % HA;
    rr = '0; gg = '0; bb = '0;
    if (act) begin
      case (md)
        0: begin
          bar = x / (HA / 8);
          case (bar)
            0: code = 7;  // white
            1: code = 6;  // yellow
            2: code = 3;  // cyan
            3: code = 2;  // green
            4: code = 5;  // magenta
            5: code = 4;  // red
            6: code = 1;  // blue
            default: code = 0;
          endcase
          rr = ((code / 4) % 2 == 1) ? CB'(MAXC) : '0;
          gg = ((code / 2) % 2 == 1) ? CB'(MAXC) : '0;
          bb = (code % 2 == 1) ? CB'(MAXC) : '0;
        end
        1: begin
          rr = CB'(x / (HA >> CB));
          gg = rr;
          bb = rr;
        end
        2: begin
          rr = (((x / 32) + (v / 32)) % 2 == 0) ? CB'(MAXC) : '0;
          gg = rr;
          bb = rr;
        end
        default: {rr, gg, bb} = col;
      endcase
    end
    return {fs, hs, vs, act, rr, gg, bb};
  endfunction

  // Model: one expected output per clock edge.
  initial begin
    exp_t e;
    m_h = 0; m_v = 0; m_mode = 0; m_off = 0; m_col = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e.val = {1'b0, 1'b1, 1'b1, 1'b0, {(3*CB){1'b0}}};
        e.h = -1;
        e.v = -1;
        m_h = 0; m_v = 0; m_mode = 0; m_off = 0; m_col = '0;
      end else begin
        e.val = ref_pixel(m_h, m_v, m_mode, m_col, m_off);
        e.h = m_h;
        e.v = m_v;
        if (m_h == HT - 1 && m_v == VT - 1) begin
          m_mode = int'(mode);
          m_col = solid_rgb;
`ifdef COLORBARS_SCROLL_EN
          if (scroll) m_off = (m_off + 1) % HA;
`endif
        end
        m_h = m_h + 1;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v + 1) % VT;
        end
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs away from the active edge; also check frame period.
  initial begin
    exp_t e;
    logic [OW-1:0] got;
    int cyc = 0;
    int last_fs = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = {frame_start, hsync, vsync, de, r, g, b};
        n_checks++;
        if (got !== e.val) begin
          n_fail++;
          $display("FAIL pixel h=%0d v=%0d got fs,hs,vs,de,rgb=%b required %b",
                   e.h, e.v, got, e.val);
        end
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs != FRAME) begin
            n_fail++;
            $display("FAIL frame_period got %0d cycles required %0d", cyc - last_fs, FRAME);
          end
        end
        last_fs = cyc;
      end
      if (rst) last_fs = -1;
      if (n_fail >= 50 && !done) begin
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Stimulus: one random-time change of mode/colour/scroll per frame, one mid-frame reset.
  initial begin
    int split;
    rst = 1'b1;
    mode = 2'd0;
    solid_rgb = '0;
    scroll = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int f = 0; f < 11; f++) begin
      split = int'($urandom_range(FRAME - 50, 50));
      repeat (split) @(posedge clk);
      #1;
      if (f == 8) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      mode = (f < 8) ? 2'(f % 4) : 2'($urandom_range(3, 0));
      solid_rgb = (3*CB)'($urandom);
      scroll = (f < 6) ? 1'b1 : 1'($urandom);
      repeat (FRAME - split) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    if (!done) begin
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    end
    $finish;
  end

endmodule

// File: doc/colorbars_gen.md
# colorbars_gen

Parametrised video timing and test-pattern generator, the next generation of the fixed colour-bar design. Produces VGA-style sync, data-enable and RGB for a configurable raster size and colour depth, with four selectable patterns switched cleanly at frame boundaries. Sits between the system clock domain and the pixel output pins of the top-level TinyTapeout wrapper.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- COLOR_BITS, 2, bits per colour channel
- SYNC_NEG, 1, 1 = sync pulses active-low, 0 = active-high

Ports:
- clk  in  1  pixel clock; every flop on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  pattern select: 0 bars, 1 grey ramp, 2 checkerboard, 3 solid
- solid_rgb  in  3*COLOR_BITS  colour for mode 3, {R,G,B}
- scroll  in  1  enable horizontal scroll (only with COLORBARS_SCROLL_EN)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video qualifier
- r, g, b  out  COLOR_BITS each  pixel colour
- frame_start  out  1  one-cycle pulse on first active pixel of each frame

## Operation

- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (525).
- hcnt counts 0..H_TOTAL-1 every cycle, wraps to 0; vcnt increments when hcnt wraps, counts 0..V_TOTAL-1, wraps to 0.
- Active when hcnt < H_ACTIVE and vcnt < V_ACTIVE. Sync asserted when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (likewise vertical). Asserted level is 0 if SYNC_NEG=1, else 1.
- Pattern x = hcnt (plus scroll offset, see Configuration).
- Mode 0 bars: 8 bars, each H_ACTIVE/8 wide, order white, yellow, cyan, green, magenta, red, blue, black. Channel on = all ones, off = 0. Bar index comes from a segment counter (no divider), reset at start of active line.
- Mode 1 ramp: r=g=b = step index; 2^COLOR_BITS equal steps across the line, step width H_ACTIVE>>COLOR_BITS, from 0 to max.
- Mode 2 checkerboard: 32x32 squares; white when x[5]^vcnt[5]=0, else black.
- Mode 3 solid: solid_rgb.
- Outside active region r,g,b = 0 and de = 0.
- mode and solid_rgb are sampled into shadow registers only on the last cycle of a frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1); mid-frame changes take effect on the next frame, never mid-line.
- Reset: hcnt=vcnt=0, shadow mode=0, shadow colour=0, scroll offset=0.

## Timing

- All outputs registered; outputs in cycle n+1 reflect counter state of cycle n. hsync, vsync, de, RGB and frame_start share this one-cycle latency and stay mutually aligned.
- Reset values of outputs: hsync and vsync at deasserted level (1 when SYNC_NEG=1), de=0, r=g=b=0, frame_start=0.
- First cycle after rst deasserts, counters are at (0,0); outputs show pixel (0,0) one cycle later with frame_start=1.
- rst asserted mid-frame: next edge returns everything to reset state; no partial-frame continuation.
- frame_start high for exactly one cycle per V_TOTAL*H_TOTAL cycles.

## Configuration

- COLORBARS_SCROLL_EN defined: 10-bit-or-wider offset register, incremented by 1 (mod H_ACTIVE) at each frame end when scroll=1; holds when scroll=0. Pattern x = (hcnt+offset) wrapped into 0..H_ACTIVE-1, applied to modes 0, 1 and 2.
- Undefined: no offset logic, x = hcnt, scroll port present but ignored.

## Test plan

- Reset then free run, defaults: hsync low for 96 cycles per 800-cycle line, starting at hcnt 656; vsync low for 2 lines starting at line 490; frame period 420000 cycles.
- mode=0: line 0 pixels 0..79 RGB=(3,3,3), 80..159 (3,3,0), ..., 560..639 (0,0,0); pixel 640 de=0, RGB=0.
- mode=1, COLOR_BITS=2: pixels 0..159 grey 0, 160..319 grey 1, 320..479 grey 2, 480..639 grey 3.
- Change mode 0->2 at line 100: rest of frame stays bars; next frame pixel (0,0) white, (32,0) black, (32,32) white.
- With COLORBARS_SCROLL_EN, mode=0, scroll=1: after 5 frames, first black bar pixel at x=555; scroll=0 freezes offset.
- Assert rst for one cycle at line 200: next cycle outputs at reset values, counters restart, frame_start pulses on the following cycle.
